// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine and its request-side client.
package gcd_pkg;

    localparam int GCD_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } client_state_e;

endpackage

// File: rtl/gcd_client_watchdog.sv
// WAIT-cycle watchdog for gcd_client: counts while run is high and flags the
// cycle in which the count reaches TIMEOUT_CYCLES-1.
module gcd_client_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_reg;

    // Saturating so a lingering run after expiry cannot wrap back into range.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg <= '0;
        end else if (!run) begin
            cnt_reg <= '0;
        end else if (cnt_reg != LIMIT) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign expire = run && (cnt_reg == LIMIT);

endmodule

// File: rtl/gcd_client.sv
// Request-side initiator for the GCD engine start/valid handshake.
// Optional watchdog timeout is compiled in with GCD_CLIENT_TIMEOUT_EN.
module gcd_client
    import gcd_pkg::*;
#(
    parameter int DATA_W         = GCD_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] req_a_i,
    input  logic [DATA_W-1:0] req_b_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_result_o,
    output logic              rsp_err_o,
    output logic              eng_start_o,
    output logic [DATA_W-1:0] eng_a_o,
    output logic [DATA_W-1:0] eng_b_o,
    input  logic              eng_valid_i,
    input  logic [DATA_W-1:0] eng_result_i,
    output logic              busy_o,
    output logic [CNT_W-1:0]  done_cnt_o
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("gcd_client: TIMEOUT_CYCLES must be at least 1");
    end

    client_state_e      state_reg;
    logic               eng_start_reg;
    logic [DATA_W-1:0]  op_a_reg;
    logic [DATA_W-1:0]  op_b_reg;
    logic               rsp_valid_reg;
    logic [DATA_W-1:0]  rsp_result_reg;
    logic [CNT_W-1:0]   done_cnt_reg;

`ifdef GCD_CLIENT_TIMEOUT_EN
    logic expire;
    logic rsp_err_reg;

    gcd_client_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .run    (state_reg == ST_WAIT),
        .expire (expire)
    );

    assign rsp_err_o = rsp_err_reg;
`else
    assign rsp_err_o = 1'b0;
`endif

    // Accept only when the response slot is free or draining this cycle, so a
    // completion can never land on an occupied slot.
    assign req_ready_o = (state_reg == ST_IDLE) && (!rsp_valid_reg || rsp_ready_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            eng_start_reg  <= 1'b0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            done_cnt_reg   <= '0;
`ifdef GCD_CLIENT_TIMEOUT_EN
            rsp_err_reg    <= 1'b0;
`endif
        end else begin
            eng_start_reg <= 1'b0;
            if (rsp_valid_reg && rsp_ready_i) begin
                rsp_valid_reg  <= 1'b0;
                rsp_result_reg <= '0;
`ifdef GCD_CLIENT_TIMEOUT_EN
                rsp_err_reg    <= 1'b0;
`endif
            end
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        op_a_reg      <= req_a_i;
                        op_b_reg      <= req_b_i;
                        eng_start_reg <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the expiry cycle takes priority over the timeout.
                    if (eng_valid_i) begin
                        rsp_result_reg <= eng_result_i;
                        rsp_valid_reg  <= 1'b1;
                        done_cnt_reg   <= done_cnt_reg + CNT_W'(1);
                        state_reg      <= ST_IDLE;
`ifdef GCD_CLIENT_TIMEOUT_EN
                        rsp_err_reg    <= 1'b0;
                    end else if (expire) begin
                        rsp_result_reg <= '0;
                        rsp_valid_reg  <= 1'b1;
                        rsp_err_reg    <= 1'b1;
                        state_reg      <= ST_IDLE;
`endif
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign eng_start_o  = eng_start_reg;
    assign eng_a_o      = op_a_reg;
    assign eng_b_o      = op_b_reg;
    assign rsp_valid_o  = rsp_valid_reg;
    assign rsp_result_o = rsp_result_reg;
    assign done_cnt_o   = done_cnt_reg;
    assign busy_o       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_gcd_client.sv
// Scoreboard bench for gcd_client: directed requests, behavioural engine model,
// and a response monitor that checks every drained response.
module tb_gcd_client;

    localparam int DW = 32;
    localparam int CW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [DW-1:0] req_a, req_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_err;
    logic          eng_start;
    logic [DW-1:0] eng_a, eng_b;
    logic          eng_valid;
    logic [DW-1:0] eng_result;
    logic          busy;
    logic [CW-1:0] done_cnt;

    gcd_client #(
        .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_err_o(rsp_err),
        .eng_start_o(eng_start), .eng_a_o(eng_a), .eng_b_o(eng_b),
        .eng_valid_i(eng_valid), .eng_result_i(eng_result),
        .busy_o(busy), .done_cnt_o(done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            lat;
        int unsigned   start_cyc;
    } op_t;

    typedef struct {
        logic [DW-1:0] res;
        logic          err;
        logic [CW-1:0] cnt;
    } rsp_t;

    op_t           op_q[$];
    rsp_t          rsp_q[$];
    logic [CW-1:0] cnt_model;
    int            stray_req = 0;
    int            tests = 0;
    int            fails = 0;
    int unsigned   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] gcd_of(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] x, y, t;
        x = a; y = b;
        while (y != 0) begin
            t = x % y; x = y; y = t;
        end
        return x;
    endfunction

    // Engine model: lat cycles after seeing start, pulse valid with the gcd; lat 0 never answers.
    initial begin
        int            cd;
        int            stray_seen;
        logic [DW-1:0] res;
        bit            prev_start;
        op_t           o;
        cd = 0; stray_seen = 0; res = '0; prev_start = 1'b0;
        eng_valid = 1'b0; eng_result = '0;
        forever begin
            @(posedge clk); #1;
            eng_valid = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin eng_valid = 1'b1; eng_result = res; end
            end
            if (stray_seen != stray_req) begin
                stray_seen = stray_req;
                eng_valid  = 1'b1;
                eng_result = 99;
            end
            if (eng_start === 1'b1) begin
                check("start_single_cycle", 64'(prev_start), 64'd0);
                if (op_q.size() == 0) begin
                    check("start_unexpected", 64'd1, 64'd0);
                end else begin
                    o = op_q.pop_front();
                    check("start_cycle", 64'(cyc), 64'(o.start_cyc));
                    check("eng_a", 64'(eng_a), 64'(o.a));
                    check("eng_b", 64'(eng_b), 64'(o.b));
                    res = gcd_of(eng_a, eng_b);
                    cd  = o.lat;
                end
            end
            prev_start = eng_start;
        end
    end

    // Response monitor: pops the scoreboard on each handshake, checks hold under backpressure.
    initial begin
        rsp_t          e;
        bit            hold;
        logic [DW-1:0] hr;
        logic          he;
        hold = 1'b0; hr = '0; he = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin hold = 1'b0; continue; end
            if (rsp_valid) begin
                if (hold) begin
                    check("hold_result", 64'(rsp_result), 64'(hr));
                    check("hold_err", 64'(rsp_err), 64'(he));
                end
                if (rsp_ready) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_rsp", 64'd1, 64'd0);
                    end else begin
                        e = rsp_q.pop_front();
                        check("rsp_result", 64'(rsp_result), 64'(e.res));
                        check("rsp_err", 64'(rsp_err), 64'(e.err));
                        check("done_cnt", 64'(done_cnt), 64'(e.cnt));
                        $display("[TB] rsp result=%0d err=%0d cnt=%0d", rsp_result, rsp_err, done_cnt);
                    end
                    hold = 1'b0;
                end else begin
                    hold = 1'b1; hr = rsp_result; he = rsp_err;
                end
            end else begin
                hold = 1'b0;
            end
        end
    end

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] res,
                        input int lat, input bit err, output int waited);
        op_t  o;
        rsp_t r;
        bit   ok;
        ok = 1'b0; waited = 0;
        req_a = a; req_b = b; req_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (req_ready) begin
                o.a = a; o.b = b; o.lat = lat; o.start_cyc = cyc + 1;
                op_q.push_back(o);
                if (!err) cnt_model = cnt_model + 1'b1;
                r.res = err ? '0 : res; r.err = err; r.cnt = cnt_model;
                rsp_q.push_back(r);
                waited = i; ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'd0, 64'd1);
        $display("[TB] req a=%0d b=%0d lat=%0d expect=%0d err=%0d", a, b, lat, res, err);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && !busy && !rsp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) check("idle_timeout", 64'd0, 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_eng_start"}, 64'(eng_start), 64'd0);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        check({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
        check({tag, "_eng_a"}, 64'(eng_a), 64'd0);
        check({tag, "_eng_b"}, 64'(eng_b), 64'd0);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        op_q.delete();
        rsp_q.delete();
        cnt_model = '0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got cycle %0d, expected done", cyc);
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int w;
        bit seen;
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        cnt_model = '0;
        #2;
        check_reset_outputs("init");
        repeat (2) @(posedge clk);
        #3; rst = 1'b0;
        @(posedge clk); #1;

        // Basic transaction
        send(48, 18, 6, 10, 1'b0, w);
        wait_idle();
        check("basic_done_cnt", 64'(done_cnt), 64'd1);

        // Backpressure with a second request pending
        rsp_ready = 1'b0;
        send(12, 8, 4, 3, 1'b0, w);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        check("bp_rsp_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
        req_a = 35; req_b = 14; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_req_ready_low", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        send(35, 14, 7, 4, 1'b0, w);
        check("bp_accept_same_cycle", 64'(w), 64'd0);
        wait_idle();

        // Stray engine valid while idle
        stray_req++;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("stray_no_rsp", 64'(seen), 64'd0);
        check("stray_done_cnt", 64'(done_cnt), 64'(cnt_model));
        @(posedge clk); #1;

        // Reset three cycles into WAIT; the engine still answers later
        send(21, 14, 7, 30, 1'b0, w);
        repeat (4) @(posedge clk);
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        check("reset_no_late_rsp", 64'(seen), 64'd0);
        check("reset_done_cnt", 64'(done_cnt), 64'd0);
        @(posedge clk); #1;

        // Valid exactly in what would be the watchdog expiry cycle
        send(9, 6, 3, TO, 1'b0, w);
        wait_idle();
`ifdef GCD_CLIENT_TIMEOUT_EN
        // Engine never answers: error response, counter untouched
        send(9, 6, 0, 0, 1'b1, w);
        wait_idle();
        check("timeout_done_cnt", 64'(done_cnt), 64'(cnt_model));
        // Valid one cycle after expiry is ignored
        send(10, 4, 0, TO + 1, 1'b1, w);
        wait_idle();
        check("late_done_cnt", 64'(done_cnt), 64'(cnt_model));
`endif

        // Counter wrap: 17 completions from reset
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            send(DW'(6 * k), DW'(4 * k), DW'(2 * k), (k % 3) + 1, 1'b0, w);
            wait_idle();
        end
        check("wrap_done_cnt", 64'(done_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gcd_client.md
# gcd_client

Request-side initiator for the GCD engine's start/valid handshake. It accepts operand pairs on a valid/ready request stream and drives one engine transaction per pair: a single-cycle start pulse with held operands. It captures the engine's one-cycle valid pulse and result, and presents the result on a valid/ready response stream. It sits between the system request path and a single GCD engine, for which it is the sole master.

## Interface
- DATA_W, 32, operand/result width
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT cycles (used only with the watchdog compiled in)
- CNT_W, 16, completion counter width
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request offered
- req_ready_o  out  1  request accepted when both valid and ready are high
- req_a_i, req_b_i  in  DATA_W  operands
- rsp_valid_o  out  1  response slot full
- rsp_ready_i  in  1  consumer takes the response
- rsp_result_o  out  DATA_W  result
- rsp_err_o  out  1  response produced by a timeout
- eng_start_o  out  1  engine start pulse
- eng_a_o, eng_b_o  out  DATA_W  engine operands
- eng_valid_i  in  1  engine done pulse
- eng_result_i  in  DATA_W  engine result
- busy_o  out  1  transaction in flight (state != IDLE)
- done_cnt_o  out  CNT_W  successful completions, wraps

## Operation
- **FSM states:** IDLE, ISSUE, WAIT.
- **IDLE:**
  - req_ready_o = !rsp_valid_o || rsp_ready_i. This path is combinational from rsp_ready_i.
  - On accept: latch req_a_i and req_b_i into operand registers, then go to ISSUE.
- **ISSUE:** eng_start_o = 1 for exactly one cycle, then go to WAIT.
- **WAIT:**
  - eng_start_o = 0.
  - On eng_valid_i: write eng_result_i to the response register, set rsp_valid_o = 1 and rsp_err_o = 0, increment done_cnt_o, go to IDLE.
- **Operand outputs:** eng_a_o and eng_b_o are always driven from the operand registers. They change only on accept.
- **Response register:** cleared on rsp_valid_o && rsp_ready_i. Because a new request is accepted only when the slot is free or draining, a valid pulse can never find the slot full.
- **Stray valid:** eng_valid_i outside WAIT is ignored.
- **Reset:**
  - State returns to IDLE.
  - Outputs reset to: eng_start_o 0, rsp_valid_o 0, rsp_err_o 0, rsp_result_o 0, eng_a_o 0, eng_b_o 0, done_cnt_o 0, busy_o 0.
  - Reset mid-transaction abandons the transaction. No response is produced.
- **Counter:** done_cnt_o wraps from 2^CNT_W−1 to 0.

## Timing
- **Accept → start:** request accepted at edge N; eng_start_o is high during cycle N+1 and low from N+2.
- **Completion:** eng_valid_i high in cycle M (M ≥ N+2). At edge M:
  - rsp_valid_o = 1;
  - the state is IDLE;
  - req_ready_o may be 1 in cycle M+1 if the response drains in that cycle.
- **Minimum spacing:** back-to-back requests are spaced by at least engine latency + 2 cycles.
- **Response hold:** the response stays stable while rsp_valid_o && !rsp_ready_i.

## Configuration
- Macro: GCD_CLIENT_TIMEOUT_EN.
- **Defined:**
  - A watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES−1 with no eng_valid_i, the block writes a response with result 0 and rsp_err_o = 1, does not increment done_cnt_o, and goes to IDLE.
  - If eng_valid_i arrives in the same cycle as expiry, the valid wins and a normal response is produced.
  - A late valid after timeout is ignored. Recovering the engine is the system's job.
- **Undefined:** WAIT is held indefinitely, rsp_err_o is tied to 0, and no watchdog logic is present.

## Structure
- **Package gcd_pkg:**
  - client state enum (IDLE, ISSUE, WAIT);
  - default DATA_W localparam, shared with the engine.
- **Sub-module gcd_client_watchdog:**
  - instantiated only under GCD_CLIENT_TIMEOUT_EN;
  - inputs: clk_i, rst_i, run (state == WAIT);
  - output: expire pulse;
  - parameter: TIMEOUT_CYCLES.
- The FSM, operand registers and response register stay in gcd_client.

## Test plan
- **Basic transaction:** request (48, 18); engine model returns 6 after 10 cycles. Expect:
  - eng_start_o high exactly one cycle at N+1, with eng_a_o = 48 and eng_b_o = 18;
  - rsp_result_o = 6 and rsp_err_o = 0;
  - done_cnt_o = 1.
- **Backpressure:** rsp_ready_i held low for 5 cycles after a response, second request (35, 14) pending. Expect req_ready_o = 0 throughout. When rsp_ready_i rises, the second request is accepted in the same cycle; result 7 is then delivered.
- **Stray valid:** pulse eng_valid_i = 1 with eng_result_i = 99 while in IDLE. Expect no rsp_valid_o and done_cnt_o unchanged.
- **Reset mid-WAIT:** assert rst_i 3 cycles into WAIT. Expect all outputs at reset values immediately. A later engine valid produces no response.
- **Timeout (GCD_CLIENT_TIMEOUT_EN, TIMEOUT_CYCLES = 16):** engine model never responds. Expect rsp_valid_o = 1, rsp_err_o = 1, rsp_result_o = 0 after 16 WAIT cycles, and done_cnt_o unchanged. Repeat with valid in the expiry cycle: expect a normal response.
- **Counter wrap (CNT_W = 4):** 17 transactions. Expect done_cnt_o = 1.
